ysyx_22040386_mem_arbiter: RTL and testbench

Shares one single-outstanding memory port between instruction fetch (IFU) and data access (MEMU) in the 5-stage RV64 core. Arbitrates with MEM priority plus a starvation guard for IF, sequences each transaction through a request/response FSM, and returns read data or write completion to the owning requester. It sits between the IFU/MEMU and the pmem/CLINT bus, replacing the DPI direct-access path.

---
 rtl/ysyx_22040386_pkg.sv | 26 ++
 rtl/ysyx_22040386_mem_arbiter_if.sv | 48 ++++
 rtl/ysyx_22040386_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_ysyx_22040386_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_pkg.sv
// rtl/ysyx_22040386_pkg.sv - shared types and widths for the IF/MEM memory arbiter
package ysyx_22040386_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_MASK_W = 8;
    localparam int ARB_INST_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_e;

    // Instructions are 32-bit; the bus word carries two, selected by address bit 2.
    function automatic logic [ARB_INST_W-1:0] pick_inst(input logic [ARB_DATA_W-1:0] word,
                                                        input logic              hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22040386_mem_arbiter_if.sv
// rtl/ysyx_22040386_mem_arbiter_if.sv - requester and downstream bus signals of the arbiter
interface ysyx_22040386_mem_arbiter_if;
    import ysyx_22040386_pkg::*;

    logic                  i_ARB_if_req;
    logic [ARB_ADDR_W-1:0] i_ARB_if_addr;
    logic                  i_ARB_flush;
    logic                  o_ARB_if_gnt;
    logic                  o_ARB_if_rvalid;
    logic [ARB_INST_W-1:0] o_ARB_if_rdata;

    logic                  i_ARB_mem_req;
    logic                  i_ARB_mem_we;
    logic [ARB_ADDR_W-1:0] i_ARB_mem_addr;
    logic [ARB_DATA_W-1:0] i_ARB_mem_wdata;
    logic [ARB_MASK_W-1:0] i_ARB_mem_wmask;
    logic                  o_ARB_mem_gnt;
    logic                  o_ARB_mem_rvalid;
    logic [ARB_DATA_W-1:0] o_ARB_mem_rdata;

    logic                  o_ARB_bus_valid;
    logic                  i_ARB_bus_ready;
    logic                  o_ARB_bus_we;
    logic [ARB_ADDR_W-1:0] o_ARB_bus_addr;
    logic [ARB_DATA_W-1:0] o_ARB_bus_wdata;
    logic [ARB_MASK_W-1:0] o_ARB_bus_wmask;
    logic                  i_ARB_bus_rvalid;
    logic [ARB_DATA_W-1:0] i_ARB_bus_rdata;

    modport slave (
        input  i_ARB_if_req, i_ARB_if_addr, i_ARB_flush,
        output o_ARB_if_gnt, o_ARB_if_rvalid, o_ARB_if_rdata,
        input  i_ARB_mem_req, i_ARB_mem_we, i_ARB_mem_addr, i_ARB_mem_wdata, i_ARB_mem_wmask,
        output o_ARB_mem_gnt, o_ARB_mem_rvalid, o_ARB_mem_rdata,
        output o_ARB_bus_valid, o_ARB_bus_we, o_ARB_bus_addr, o_ARB_bus_wdata, o_ARB_bus_wmask,
        input  i_ARB_bus_ready, i_ARB_bus_rvalid, i_ARB_bus_rdata
    );

    modport master (
        output i_ARB_if_req, i_ARB_if_addr, i_ARB_flush,
        input  o_ARB_if_gnt, o_ARB_if_rvalid, o_ARB_if_rdata,
        output i_ARB_mem_req, i_ARB_mem_we, i_ARB_mem_addr, i_ARB_mem_wdata, i_ARB_mem_wmask,
        input  o_ARB_mem_gnt, o_ARB_mem_rvalid, o_ARB_mem_rdata,
        input  o_ARB_bus_valid, o_ARB_bus_we, o_ARB_bus_addr, o_ARB_bus_wdata, o_ARB_bus_wmask,
        output i_ARB_bus_ready, i_ARB_bus_rvalid, i_ARB_bus_rdata
    );

endinterface

// File: rtl/ysyx_22040386_mem_arbiter.sv
// rtl/ysyx_22040386_mem_arbiter.sv - single-outstanding IF/MEM arbiter onto the pmem/CLINT bus
module ysyx_22040386_mem_arbiter
    import ysyx_22040386_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                         i_ARB_clk,
    input  logic                         i_ARB_rst,
    ysyx_22040386_mem_arbiter_if.slave   arb
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q;
    logic                  drop_q;
    logic [CNT_W-1:0]      starve_q;

    logic                  bus_we_q;
    logic [ARB_ADDR_W-1:0] bus_addr_q;
    logic [ARB_DATA_W-1:0] bus_wdata_q;
    logic [ARB_MASK_W-1:0] bus_wmask_q;

    logic                  if_rvalid_q;
    logic [ARB_INST_W-1:0] if_rdata_q;
    logic                  mem_rvalid_q;
    logic [ARB_DATA_W-1:0] mem_rdata_q;

    logic if_cand, starved, pick_mem, pick_if;
    logic grant_if, grant_mem, resp_done, if_deliver;

    // Grants are combinational in IDLE, so they are gated by reset to keep outputs quiet.
    always_comb begin
        if_cand    = arb.i_ARB_if_req & ~arb.i_ARB_flush;
        starved    = (starve_q == STARVE_LIM);
        pick_mem   = arb.i_ARB_mem_req & ~(if_cand & starved);
        pick_if    = if_cand & ~pick_mem;
        grant_mem  = (state_q == ST_IDLE) & ~i_ARB_rst & pick_mem;
        grant_if   = (state_q == ST_IDLE) & ~i_ARB_rst & pick_if;
        resp_done  = (state_q == ST_RESP) & arb.i_ARB_bus_rvalid;
        if_deliver = resp_done & (owner_q == OWN_IF) & ~drop_q & ~arb.i_ARB_flush;
    end

    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_if || grant_mem)    state_d = ST_REQ;
            ST_REQ:  if (arb.i_ARB_bus_ready)      state_d = ST_RESP;
            ST_RESP: if (arb.i_ARB_bus_rvalid)     state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arb.o_ARB_if_gnt    = grant_if;
        arb.o_ARB_mem_gnt   = grant_mem;
        arb.o_ARB_bus_valid = (state_q == ST_REQ);
    end

    assign arb.o_ARB_bus_we     = bus_we_q;
    assign arb.o_ARB_bus_addr   = bus_addr_q;
    assign arb.o_ARB_bus_wdata  = bus_wdata_q;
    assign arb.o_ARB_bus_wmask  = bus_wmask_q;
    assign arb.o_ARB_if_rvalid  = if_rvalid_q;
    assign arb.o_ARB_if_rdata   = if_rdata_q;
    assign arb.o_ARB_mem_rvalid = mem_rvalid_q;
    assign arb.o_ARB_mem_rdata  = mem_rdata_q;

    // Fetches never write: their write fields are forced to zero at latch time.
    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            owner_q     <= OWN_IF;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= arb.i_ARB_if_addr;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end else if (grant_mem) begin
            owner_q     <= OWN_MEM;
            bus_we_q    <= arb.i_ARB_mem_we;
            bus_addr_q  <= arb.i_ARB_mem_addr;
            bus_wdata_q <= arb.i_ARB_mem_wdata;
            bus_wmask_q <= arb.i_ARB_mem_wmask;
        end
    end

    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            starve_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (grant_mem && arb.i_ARB_if_req) begin
                if (!starved) starve_q <= starve_q + CNT_W'(1);
            end else if (grant_if || !arb.i_ARB_if_req) begin
                starve_q <= '0;
            end
        end
    end

    // A redirect during an in-flight fetch lets the bus finish but swallows the result.
    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            drop_q <= 1'b0;
        end else if (grant_if || grant_mem || resp_done) begin
            drop_q <= 1'b0;
        end else if ((state_q != ST_IDLE) && (owner_q == OWN_IF) && arb.i_ARB_flush) begin
            drop_q <= 1'b1;
        end
    end

    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            if_rvalid_q  <= if_deliver;
            mem_rvalid_q <= resp_done & (owner_q == OWN_MEM);
            if (if_deliver) begin
                if_rdata_q <= pick_inst(arb.i_ARB_bus_rdata, bus_addr_q[2]);
            end
            if (resp_done && (owner_q == OWN_MEM)) begin
                mem_rdata_q <= bus_we_q ? '0 : arb.i_ARB_bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// tb/tb_ysyx_22040386_mem_arbiter.sv - scoreboard bench for the IF/MEM memory arbiter
module tb_ysyx_22040386_mem_arbiter;

    typedef struct {
        bit          is_mem;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22040386_mem_arbiter_if arb_if();

    ysyx_22040386_mem_arbiter #(.STARVE_MAX(4)) dut (
        .i_ARB_clk (clk),
        .i_ARB_rst (rst),
        .arb       (arb_if)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_delay  = 0;
    int          rvalid_delay = 0;
    logic [63:0] resp_data    = '0;

    logic [63:0] s_if_gnt, s_mem_gnt, s_bus_valid, s_bus_we, s_bus_addr;
    logic [63:0] s_bus_wdata, s_bus_wmask, s_if_rvalid, s_mem_rvalid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_inst(input logic [63:0] a, input logic [63:0] d);
        return a[2] ? {32'd0, d[63:32]} : {32'd0, d[31:0]};
    endfunction

    function automatic void push_exp(input bit m, input logic [63:0] d);
        exp_t e;
        e.is_mem = m;
        e.data   = d;
        sb.push_back(e);
    endfunction

    // Sample the cycle whose inputs were just driven, score any completion, advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_if_gnt     = 64'(arb_if.o_ARB_if_gnt);
        s_mem_gnt    = 64'(arb_if.o_ARB_mem_gnt);
        s_bus_valid  = 64'(arb_if.o_ARB_bus_valid);
        s_bus_we     = 64'(arb_if.o_ARB_bus_we);
        s_bus_addr   = arb_if.o_ARB_bus_addr;
        s_bus_wdata  = arb_if.o_ARB_bus_wdata;
        s_bus_wmask  = 64'(arb_if.o_ARB_bus_wmask);
        s_if_rvalid  = 64'(arb_if.o_ARB_if_rvalid);
        s_mem_rvalid = 64'(arb_if.o_ARB_mem_rvalid);
        if (!rst && (arb_if.o_ARB_if_rvalid || arb_if.o_ARB_mem_rvalid)) begin
            if (sb.size() == 0) begin
                check("rvalid_spurious", 64'({arb_if.o_ARB_if_rvalid, arb_if.o_ARB_mem_rvalid}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_owner", 64'({arb_if.o_ARB_if_rvalid, arb_if.o_ARB_mem_rvalid}),
                      e.is_mem ? 64'd1 : 64'd2);
                if (e.is_mem) check("mem_rdata", arb_if.o_ARB_mem_rdata, e.data);
                else          check("if_rdata", 64'(arb_if.o_ARB_if_rdata), e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick();
        check("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin : bus_model
        int phase;
        int wait_n;
        phase  = 0;
        wait_n = 0;
        arb_if.i_ARB_bus_ready  = 1'b0;
        arb_if.i_ARB_bus_rvalid = 1'b0;
        arb_if.i_ARB_bus_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            arb_if.i_ARB_bus_ready  = 1'b0;
            arb_if.i_ARB_bus_rvalid = 1'b0;
            arb_if.i_ARB_bus_rdata  = ~resp_data;
            if (rst) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (arb_if.o_ARB_bus_valid) begin
                           if (ready_delay == 0) begin
                               arb_if.i_ARB_bus_ready = 1'b1;
                               phase  = 2;
                               wait_n = rvalid_delay;
                           end else begin
                               wait_n = ready_delay - 1;
                               phase  = 1;
                           end
                       end
                    1: if (wait_n == 0) begin
                           arb_if.i_ARB_bus_ready = 1'b1;
                           phase  = 2;
                           wait_n = rvalid_delay;
                       end else begin
                           wait_n--;
                       end
                    default: if (wait_n == 0) begin
                           arb_if.i_ARB_bus_rvalid = 1'b1;
                           arb_if.i_ARB_bus_rdata  = resp_data;
                           phase = 0;
                       end else begin
                           wait_n--;
                       end
                endcase
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : main
        int          grants;
        bit          exp_mem;
        logic [63:0] rv_seen;

        arb_if.i_ARB_if_req    = 1'b1;
        arb_if.i_ARB_if_addr   = '0;
        arb_if.i_ARB_flush     = 1'b0;
        arb_if.i_ARB_mem_req   = 1'b1;
        arb_if.i_ARB_mem_we    = 1'b0;
        arb_if.i_ARB_mem_addr  = '0;
        arb_if.i_ARB_mem_wdata = '0;
        arb_if.i_ARB_mem_wmask = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with both requests held high.
        tick();
        check("rst_if_gnt", s_if_gnt, 64'd0);
        check("rst_mem_gnt", s_mem_gnt, 64'd0);
        check("rst_bus_valid", s_bus_valid, 64'd0);
        check("rst_bus_addr", s_bus_addr, 64'd0);
        check("rst_bus_wmask", s_bus_wmask, 64'd0);
        check("rst_if_rvalid", s_if_rvalid, 64'd0);
        check("rst_mem_rvalid", s_mem_rvalid, 64'd0);
        arb_if.i_ARB_if_req  = 1'b0;
        arb_if.i_ARB_mem_req = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        // IF fetch, immediate bus; flush on the rvalid cycle must not eat it.
        ready_delay = 0; rvalid_delay = 0;
        resp_data = 64'h1111_2222_3333_4444;
        arb_if.i_ARB_if_req  = 1'b1;
        arb_if.i_ARB_if_addr = 64'h8000_0004;
        push_exp(1'b0, exp_inst(64'h8000_0004, resp_data));
        tick();
        check("t1_if_gnt", s_if_gnt, 64'd1);
        check("t1_bus_valid_t0", s_bus_valid, 64'd0);
        arb_if.i_ARB_if_req  = 1'b0;
        arb_if.i_ARB_if_addr = 64'h0;
        tick();
        check("t1_bus_valid_t1", s_bus_valid, 64'd1);
        check("t1_bus_addr", s_bus_addr, 64'h8000_0004);
        check("t1_bus_we", s_bus_we, 64'd0);
        tick();
        check("t1_bus_valid_t2", s_bus_valid, 64'd0);
        arb_if.i_ARB_flush = 1'b1;
        tick();
        check("t1_if_rvalid_t3", s_if_rvalid, 64'd1);
        arb_if.i_ARB_flush = 1'b0;
        tick();
        check("t1_if_rvalid_t4", s_if_rvalid, 64'd0);

        // MEM write with ready held off for three cycles.
        ready_delay = 3;
        resp_data = 64'h5555_6666_7777_8888;
        arb_if.i_ARB_mem_req   = 1'b1;
        arb_if.i_ARB_mem_we    = 1'b1;
        arb_if.i_ARB_mem_addr  = 64'h8000_1000;
        arb_if.i_ARB_mem_wdata = 64'hDEAD_BEEF;
        arb_if.i_ARB_mem_wmask = 8'h0F;
        push_exp(1'b1, 64'd0);
        tick();
        check("t2_mem_gnt", s_mem_gnt, 64'd1);
        arb_if.i_ARB_mem_req   = 1'b0;
        arb_if.i_ARB_mem_we    = 1'b0;
        arb_if.i_ARB_mem_addr  = 64'hFFFF_0000;
        arb_if.i_ARB_mem_wdata = 64'h1234;
        arb_if.i_ARB_mem_wmask = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_bus_valid", s_bus_valid, 64'd1);
            check("t2_bus_we", s_bus_we, 64'd1);
            check("t2_bus_addr", s_bus_addr, 64'h8000_1000);
            check("t2_bus_wdata", s_bus_wdata, 64'hDEAD_BEEF);
            check("t2_bus_wmask", s_bus_wmask, 64'h0F);
        end
        tick();
        check("t2_bus_valid_resp", s_bus_valid, 64'd0);
        tick();
        check("t2_mem_rvalid", s_mem_rvalid, 64'd1);
        tick();
        check("t2_mem_rvalid_once", s_mem_rvalid, 64'd0);

        // Both requesting continuously: four MEM grants, then IF.
        ready_delay = 0;
        resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        arb_if.i_ARB_if_req   = 1'b1;
        arb_if.i_ARB_if_addr  = 64'h8000_0100;
        arb_if.i_ARB_mem_req  = 1'b1;
        arb_if.i_ARB_mem_we   = 1'b0;
        arb_if.i_ARB_mem_addr = 64'h8000_2000;
        grants = 0;
        for (int c = 0; c < 80 && grants < 10; c++) begin
            tick();
            if (s_if_gnt != 0 || s_mem_gnt != 0) begin
                exp_mem = (grants % 5) != 4;
                check("starve_order", {s_if_gnt[0], s_mem_gnt[0]}, exp_mem ? 64'd1 : 64'd2);
                push_exp(exp_mem, exp_mem ? resp_data : exp_inst(64'h8000_0100, resp_data));
                grants++;
            end
        end
        check("starve_grants", 64'(grants), 64'd10);
        arb_if.i_ARB_if_req  = 1'b0;
        arb_if.i_ARB_mem_req = 1'b0;
        drain(10);

        // Flush while the fetch sits in RESP: bus completes, no IF rvalid.
        rvalid_delay = 2;
        resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
        arb_if.i_ARB_if_req  = 1'b1;
        arb_if.i_ARB_if_addr = 64'h8000_0008;
        tick();
        check("t4_if_gnt", s_if_gnt, 64'd1);
        arb_if.i_ARB_if_req = 1'b0;
        tick();
        check("t4_bus_valid", s_bus_valid, 64'd1);
        arb_if.i_ARB_flush = 1'b1;
        tick();
        arb_if.i_ARB_flush = 1'b0;
        rv_seen = 64'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            rv_seen = rv_seen | s_if_rvalid;
        end
        check("t4_if_rvalid_dropped", rv_seen, 64'd0);
        rvalid_delay = 0;
        resp_data = 64'h0123_4567_89AB_CDEF;
        arb_if.i_ARB_mem_req  = 1'b1;
        arb_if.i_ARB_mem_addr = 64'h8000_3000;
        push_exp(1'b1, resp_data);
        tick();
        check("t4_mem_gnt", s_mem_gnt, 64'd1);
        arb_if.i_ARB_mem_req = 1'b0;
        drain(10);

        // Reset while REQ drives the bus.
        ready_delay = 5;
        arb_if.i_ARB_mem_req  = 1'b1;
        arb_if.i_ARB_mem_addr = 64'h8000_4000;
        tick();
        check("t5_mem_gnt", s_mem_gnt, 64'd1);
        arb_if.i_ARB_mem_req = 1'b0;
        tick();
        check("t5_bus_valid", s_bus_valid, 64'd1);
        arb_if.i_ARB_mem_req = 1'b1;
        rst = 1'b1;
        #2;
        check("t5_async_bus_valid", 64'(arb_if.o_ARB_bus_valid), 64'd0);
        check("t5_async_mem_gnt", 64'(arb_if.o_ARB_mem_gnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        arb_if.i_ARB_mem_req = 1'b0;
        ready_delay = 0;
        rv_seen = 64'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            rv_seen = rv_seen | s_if_rvalid | s_mem_rvalid;
        end
        check("t5_no_rvalid", rv_seen, 64'd0);
        resp_data = 64'hCAFE_F00D_1357_2468;
        arb_if.i_ARB_if_req  = 1'b1;
        arb_if.i_ARB_if_addr = 64'h8000_000C;
        push_exp(1'b0, exp_inst(64'h8000_000C, resp_data));
        tick();
        check("t5_if_gnt", s_if_gnt, 64'd1);
        arb_if.i_ARB_if_req = 1'b0;
        drain(10);

        // Flush in IDLE: MEM may still win; a lone IF gets nothing that cycle.
        resp_data = 64'h7777_0000_9999_1111;
        arb_if.i_ARB_flush    = 1'b1;
        arb_if.i_ARB_if_req   = 1'b1;
        arb_if.i_ARB_if_addr  = 64'h8000_0010;
        arb_if.i_ARB_mem_req  = 1'b1;
        arb_if.i_ARB_mem_addr = 64'h8000_5000;
        push_exp(1'b1, resp_data);
        tick();
        check("t6_mem_gnt", s_mem_gnt, 64'd1);
        check("t6_if_gnt", s_if_gnt, 64'd0);
        arb_if.i_ARB_flush   = 1'b0;
        arb_if.i_ARB_if_req  = 1'b0;
        arb_if.i_ARB_mem_req = 1'b0;
        drain(10);
        arb_if.i_ARB_flush  = 1'b1;
        arb_if.i_ARB_if_req = 1'b1;
        tick();
        check("t6_if_gnt_flush", s_if_gnt, 64'd0);
        check("t6_bus_idle", s_bus_valid, 64'd0);
        arb_if.i_ARB_flush = 1'b0;
        push_exp(1'b0, exp_inst(64'h8000_0010, resp_data));
        tick();
        check("t6_if_gnt_after", s_if_gnt, 64'd1);
        arb_if.i_ARB_if_req = 1'b0;
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
